pwm_capture: RTL and testbench

- Receive side of the servo PWM link: measures the high time and the period of an incoming PWM signal in CLK cycles.
- Reports the high time on the same 17-bit width scale the PWM generator uses, so a captured value can be compared directly against a commanded width.
- Sits between an external PWM source (RC receiver or a loop-back of the arm's servo outputs) and the control logic.
- Flags stalled or out-of-range signals.

---
 rtl/pwm_capture.sv | 193 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Purpose  : Receive side of the servo PWM link. Measures the high time and
//            the rising-to-rising period of an asynchronous PWM input in
//            clk_i cycles and flags overflow of the high time and stalled
//            inputs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i       in   1         system clock
//   rst_ni      in   1         synchronous reset, active low
//   pwm_in_i    in   1         asynchronous PWM input
//   width_o     out  WIDTH_W   last measured high time (cycles, saturating)
//   period_o    out  PERIOD_W  last measured rise-to-rise period (cycles)
//   valid_o     out  1         one-cycle strobe: width_o/period_o updated
//   overflow_o  out  1         high time of the last period exceeded 2^WIDTH_W-1
//   timeout_o   out  1         no edge seen for TIMEOUT_CYC cycles
// ============================================================================
module pwm_capture #(
    parameter int WIDTH_W     = 17,
    parameter int PERIOD_W    = 20,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pwm_in_i,
    output logic [WIDTH_W-1:0]  width_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                valid_o,
    output logic                overflow_o,
    output logic                timeout_o
);

    localparam logic [WIDTH_W-1:0]  H_ONE       = WIDTH_W'(1);
    localparam logic [PERIOD_W-1:0] P_ONE       = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TIMEOUT_LIM = PERIOD_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer, history flop and registered edge detect
    // ------------------------------------------------------------------
    logic       sync1_q, sync2_q, sync3_q;
    logic [2:0] prime_q;
    logic       rise_q, fall_q;

    // prime_q marks when sync3_q holds a genuine post-reset sample. Without
    // it, an input that is already high at reset release would look like a
    // rising edge (the flops come out of reset at 0) and a partial pulse
    // would be measured as if it were complete.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            prime_q <= 3'b000;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            prime_q <= {prime_q[1:0], 1'b1};
            rise_q  <= prime_q[2] &  sync2_q & ~sync3_q;
            fall_q  <= prime_q[2] & ~sync2_q &  sync3_q;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [WIDTH_W-1:0]  hcnt_q, hcnt_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic                ovf_q, ovf_d;
    logic [WIDTH_W-1:0]  width_q, width_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;

    logic [PERIOD_W-1:0] pcnt_sat;
    logic                pcnt_expired;

    always_comb begin
        pcnt_sat     = (pcnt_q == '1) ? pcnt_q : pcnt_q + P_ONE;
        pcnt_expired = (pcnt_q >= TIMEOUT_LIM);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            ovf_q      <= 1'b0;
            width_q    <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            pcnt_q     <= pcnt_d;
            ovf_q      <= ovf_d;
            width_q    <= width_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        pcnt_d     = pcnt_q;
        ovf_d      = ovf_q;
        width_d    = width_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                // A fall here is ignored: the first pulse seen after reset
                // or timeout only starts the measurement.
                if (rise_q) begin
                    hcnt_d    = H_ONE;
                    pcnt_d    = P_ONE;
                    ovf_d     = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_HIGH;
                end
            end

            S_HIGH: begin
                if (pcnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    pcnt_d = pcnt_sat;
                    if (fall_q) begin
                        // The falling edge cycle itself is not high time.
                        state_d = S_LOW;
                    end else if (hcnt_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + H_ONE;
                    end
                end
            end

            S_LOW: begin
                // A rise on the same cycle the threshold is reached still
                // closes a valid period.
                if (rise_q) begin
                    width_d    = hcnt_q;
                    period_d   = pcnt_q;
                    overflow_d = ovf_q;
                    valid_d    = 1'b1;
                    hcnt_d     = H_ONE;
                    pcnt_d     = P_ONE;
                    ovf_d      = 1'b0;
                    state_d    = S_HIGH;
                end else if (pcnt_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    pcnt_d = pcnt_sat;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign width_o    = width_q;
    assign period_o   = period_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_capture
// Purpose  : Self-checking bench for pwm_capture. Directed scenarios followed
//            by randomized pulse trains. An event-level model (logs of input
//            rise/fall cycles) predicts every output on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int WW   = 8;
    localparam int PW   = 11;
    localparam int TO   = 1000;
    localparam int WMAX = (1 << WW) - 1;
    localparam int LAT  = 4;   // input edge to registered output

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          pwm    = 1'b0;
    logic [WW-1:0] width;
    logic [PW-1:0] period;
    logic          valid;
    logic          overflow;
    logic          timeout;

    pwm_capture #(
        .WIDTH_W     (WW),
        .PERIOD_W    (PW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pwm_in_i   (pwm),
        .width_o    (width),
        .period_o   (period),
        .valid_o    (valid),
        .overflow_o (overflow),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    // Input event logs written by the driver, consumed by the model.
    int rise_log[$];
    int fall_log[$];
    int rst_eff = -1;
    bit chk_en  = 1'b0;

    // Model state: last rise the receiver is measuring from, last fall.
    int eff_last  = -1;
    int last_fall = -1;
    int ew = 0, ep = 0;
    bit eo = 1'b0, ev = 1'b0, eto = 1'b0;
    int t, r, hi;

    always @(negedge clk) begin
        if (chk_en) begin
            t  = cyc;
            ev = 1'b0;
            while (fall_log.size() > 0 && fall_log[0] + LAT <= t)
                last_fall = fall_log.pop_front();
            while (rise_log.size() > 0 && rise_log[0] + LAT <= t) begin
                r = rise_log.pop_front();
                if (eff_last >= 0 && (r - eff_last) <= TO) begin
                    hi = last_fall - eff_last;
                    ev = 1'b1;
                    ew = (hi > WMAX) ? WMAX : hi;
                    ep = r - eff_last;
                    eo = (hi > WMAX);
                end
                eff_last = r;
            end
            if (t == rst_eff) begin
                eff_last = -1;
                ew = 0;
                ep = 0;
                eo = 1'b0;
                ev = 1'b0;
            end
            eto = (eff_last >= 0) && (t >= eff_last + TO + LAT);
            check("valid",    valid,    ev);
            check("width",    width,    ew);
            check("period",   period,   ep);
            check("overflow", overflow, eo);
            check("timeout",  timeout,  eto);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        pwm = 1'b1;
        rise_log.push_back(cyc);
        step(h);
        pwm = 1'b0;
        fall_log.push_back(cyc);
        step(l);
    endtask

    initial begin
        int h, l;

        // Power-on reset
        rst_n = 1'b0;
        pwm   = 1'b0;
        step(5);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_width",   width,    0);
        check("rst_period",  period,   0);
        check("rst_valid",   valid,    0);
        check("rst_timeout", timeout,  0);
        step(10);

        // Steady train: first VALID only after the second rise
        repeat (4) pulse(75, 425);
        check("lit_w75",   width,    75);
        check("lit_p500",  period,   500);
        check("lit_ovf0",  overflow, 0);

        // Width changes each period
        pulse(50, 450);
        pulse(100, 400);
        pulse(125, 375);
        pulse(75, 425);
        check("lit_w125",  width,  125);
        check("lit_p500b", period, 500);

        // Minimum pulses: width 1, period 2
        repeat (10) pulse(1, 1);
        pulse(1, 20);
        check("lit_w1", width,  1);
        check("lit_p2", period, 2);

        // Overflow then recovery
        pulse(300, 200);
        pulse(75, 425);
        check("lit_wsat",  width,    WMAX);
        check("lit_ovf1",  overflow, 1);
        pulse(75, 425);
        check("lit_wrec",  width,    75);
        check("lit_ovfc",  overflow, 0);

        // Period exactly at the timeout threshold is still reported
        pulse(100, 900);
        pulse(10, 990);
        check("lit_pTO",   period,  TO);
        check("lit_toTO",  timeout, 0);
        pulse(10, TO + 1);
        check("lit_to1",   timeout, 1);
        check("lit_whold", width,   10);

        // Stall low after a valid period, then restart
        pulse(50, 450);
        pulse(50, TO + 10);
        check("lit_stall_to", timeout, 1);
        check("lit_stall_w",  width,   50);
        check("lit_stall_p",  period,  500);
        pulse(40, 460);
        check("lit_restart_to", timeout, 0);
        check("lit_restart_w",  width,   50);
        pulse(40, 460);
        check("lit_restart_w2", width,   40);

        // Constant high also ends in timeout
        pwm = 1'b1;
        rise_log.push_back(cyc);
        step(TO + 20);
        check("lit_high_to", timeout, 1);
        pwm = 1'b0;
        fall_log.push_back(cyc);
        step(50);
        pulse(60, 440);
        pulse(60, 440);
        check("lit_hrec_w",  width,   60);
        check("lit_hrec_to", timeout, 0);

        // One-cycle reset in the middle of a high phase
        pulse(40, 460);
        pwm = 1'b1;
        rise_log.push_back(cyc);
        step(20);
        rst_n   = 1'b0;
        rst_eff = cyc + 1;
        step(1);
        rst_n = 1'b1;
        check("lit_mrst_w", width,  0);
        check("lit_mrst_p", period, 0);
        step(30);
        pwm = 1'b0;
        fall_log.push_back(cyc);
        step(400);
        pulse(60, 440);
        pulse(70, 430);
        check("lit_post_w", width,  60);
        check("lit_post_p", period, 500);

        // Randomized pulse trains, including overflow and threshold edges
        repeat (80) begin
            h = $urandom_range(1, 300);
            if ($urandom_range(0, 15) == 0) h = 255 + $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) l = TO - h - 1 + $urandom_range(0, 2);
            else l = $urandom_range(1, 400);
            pulse(h, l);
        end
        pulse(20, 30);
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
